// File: rtl/shift_request_stage.sv
// Two-register request/response stage wrapped around a combinational right shifter.
// Stage A drives the shifter inputs from flops; stage B captures and presents the result.
module shift_request_stage #(
    parameter  int N = 8,
    localparam int A = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [A-1:0] in_amt,
    output logic [N-1:0] sh_x,
    output logic [A-1:0] sh_amt,
    input  logic [N-1:0] sh_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_z,
    output logic [7:0]   out_count
);

    logic         r_a_valid;
    logic [N-1:0] r_a_x;
    logic [A-1:0] r_a_amt;
    logic         r_b_valid;
    logic [N-1:0] r_b_z;
    logic [7:0]   r_count;

    logic         w_b_free;
    logic         w_a_move;
    logic         w_in_ready;
    logic         w_in_xfer;
    logic         w_out_xfer;

    // Handshake decisions; in_ready deliberately ignores in_valid.
    always_comb begin
        w_b_free   = !r_b_valid || out_ready;
        w_a_move   = r_a_valid && w_b_free;
        w_in_ready = !r_a_valid || w_b_free;
        w_in_xfer  = in_valid && w_in_ready;
        w_out_xfer = r_b_valid && out_ready;
    end

    // Stage A: hold the request stable on the shifter inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_x     <= '0;
            r_a_amt   <= '0;
        end else if (w_in_xfer) begin
            r_a_valid <= 1'b1;
            r_a_x     <= in_x;
            r_a_amt   <= in_amt;
        end else if (w_a_move) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B: capture the shifter result; a new result may replace one leaving.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_valid <= 1'b0;
            r_b_z     <= '0;
        end else if (w_a_move) begin
            r_b_valid <= 1'b1;
            r_b_z     <= sh_z;
        end else if (w_out_xfer) begin
            r_b_valid <= 1'b0;
        end
    end

    // Completed output transfers, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign sh_x      = r_a_x;
    assign sh_amt    = r_a_amt;
    assign out_valid = r_b_valid;
    assign out_z     = r_b_z;
    assign out_count = r_count;

endmodule

// File: tb/tb_shift_request_stage.sv
// Bench for shift_request_stage: behavioural queue model plus directed literal checks.
// The downstream shifter is modelled here with a plain >> operator.
module tb_shift_request_stage;

    localparam int N = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_x;
    logic [A-1:0] in_amt;
    logic [N-1:0] sh_x;
    logic [A-1:0] sh_amt;
    logic [N-1:0] sh_z;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_z;
    logic [7:0]   out_count;

    always #5 clk = ~clk;

    assign sh_z = sh_x >> sh_amt;

    shift_request_stage #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_amt(in_amt),
        .sh_x(sh_x), .sh_amt(sh_amt), .sh_z(sh_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_count(out_count)
    );

    typedef struct {
        logic [7:0] z;
        int         acc;
    } item_t;

    int checks = 0;
    int errors = 0;

    item_t      mq[$];
    int         m_cyc = 0;
    logic [7:0] m_x = 0;
    logic [2:0] m_amt = 0;
    int         m_cnt = 0;
    int         n_out = 0;
    int         n_in = 0;
    logic [7:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        return (mq.size() < 2) || out_ready;
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].acc < m_cyc);
    endfunction

    // Model: front result is visible one edge after it was accepted.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_x   = 0;
            m_amt = 0;
            m_cnt = 0;
        end else begin
            bit ox;
            bit ix;
            item_t it;
            ox = m_out_valid() && out_ready;
            ix = in_valid && m_in_ready();
            if (ox) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 256;
                n_out++;
            end
            if (ix) begin
                it.z   = in_x >> in_amt;
                it.acc = m_cyc + 1;
                mq.push_back(it);
                m_x   = in_x;
                m_amt = in_amt;
                n_in++;
            end
        end
        m_cyc++;
    end

    // Compare every cycle against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_out_valid());
            if (m_out_valid())
                chk("out_z", out_z, mq[0].z);
            chk("sh_x", sh_x, m_x);
            chk("sh_amt", sh_amt, m_amt);
            chk("out_count", out_count, m_cnt);
            if (out_valid && out_ready)
                got.push_back(out_z);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] x, input logic [2:0] a);
        int t = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_amt   = a;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = 0;
        in_amt    = 0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset with both stages full
        push(8'h55, 3'd1);
        push(8'h66, 3'd2);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_sh_x", sh_x, 0);
        chk("rst_sh_amt", sh_amt, 0);
        chk("rst_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single request
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'hB4;
        in_amt    = 3'd3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_sh_x", sh_x, 8'hB4);
        chk("single_sh_amt", sh_amt, 3);
        chk("single_ov0", out_valid, 0);
        @(negedge clk);
        chk("single_ov1", out_valid, 1);
        chk("single_z", out_z, 8'h16);
        step();
        chk("single_count", out_count, 1);

        // Back-to-back stream
        got.delete();
        begin
            logic [7:0] xs[4] = '{8'h80, 8'hFF, 8'hA5, 8'h01};
            logic [2:0] as[4] = '{3'd7, 3'd0, 3'd4, 3'd1};
            logic [7:0] ex[4] = '{8'h01, 8'hFF, 8'h0A, 8'h00};
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_x     = xs[i];
                in_amt   = as[i];
                @(negedge clk);
                chk("stream_in_ready", in_ready, 1);
                step();
            end
            in_valid = 1'b0;
            repeat (4) step();
            chk("stream_len", got.size(), 4);
            for (int i = 0; i < 4; i++)
                if (i < got.size()) chk("stream_z", got[i], ex[i]);
        end

        // Backpressure: two held, third refused until out_ready rises
        do_reset();
        got.delete();
        out_ready = 1'b0;
        push(8'hF0, 3'd4);
        push(8'hC3, 3'd1);
        in_valid = 1'b1;
        in_x     = 8'h81;
        in_amt   = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_z", out_z, 8'h0F);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_recover", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_len", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_z0", got[0], 8'h0F);
            chk("bp_z1", got[1], 8'h61);
            chk("bp_z2", got[2], 8'h01);
        end

        // Reset while a result is held
        out_ready = 1'b0;
        push(8'h3C, 3'd2);
        step();
        @(negedge clk);
        chk("held_ov", out_valid, 1);
        do_reset();
        got.delete();
        push(8'h99, 3'd3);
        out_ready = 1'b1;
        repeat (3) step();
        chk("post_rst_len", got.size(), 1);
        if (got.size() > 0) chk("post_rst_z", got[0], 8'h13);

        // Random traffic, 300 transfers
        do_reset();
        n_in  = 0;
        n_out = 0;
        begin
            int t = 0;
            while (n_out < 300 && t < 5000) begin
                in_valid  = (n_in < 300) && ($urandom_range(0, 3) != 0);
                in_x      = 8'($urandom);
                in_amt    = 3'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                step();
                t++;
            end
            if (t >= 5000) chk("rand_timeout", n_out, 300);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rand_in", n_in, 300);
        chk("rand_count", out_count, 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
